// File: rtl/sms_pkg.sv
// sms_pkg -- shared types and default constants for the GF(2^N) power engine.
//   state_t  : engine FSM states (IDLE, RUN, DONE)
//   N_DEF    : default field degree / data width
//   POLY_DEF : default reduction polynomial x^6+x+1
//   EW_DEF   : default exponent width
//   ID_MAT   : 6x6 identity matrix, row-major, row r column c at bit r*N+c
package sms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          N_DEF    = 6;
  localparam logic [6:0]  POLY_DEF = 7'b1000011;
  localparam int          EW_DEF   = 6;

  // Diagonal bits 0, 7, 14, 21, 28, 35.
  localparam logic [35:0] ID_MAT   = 36'h810204081;

endpackage

// File: rtl/sms_power_engine_gf_mul.sv
// gf_mul -- combinational GF(2^N) multiplier, polynomial basis.
//   a, b : operands (N bits)
//   p    : a*b mod POLY (N bits)
// Shift-and-add: the running multiple of a is reduced every step so it
// never leaves N bits.
module gf_mul #(
  parameter int         N    = 6,
  parameter logic [N:0] POLY = 7'b1000011
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  logic [N-1:0] sh;

  always_comb begin
    p  = '0;
    sh = a;
    for (int i = 0; i < N; i++) begin
      if (b[i]) p = p ^ sh;
      sh = {sh[N-2:0], 1'b0} ^ (sh[N-1] ? POLY[N-1:0] : '0);
    end
  end

endmodule

// File: rtl/sms_power_engine.sv
// sms_power_engine -- computes y = x^e in GF(2^N) by left-to-right
// square-and-multiply, one exponent bit per clock.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake, operands x_in, exp_in
//   out_valid/out_ready : result handshake, result y_out
//   busy                : engine not in IDLE
// Optional macro SMS_ISO_EN adds M_IN / M_OUT basis-change matrices:
//   y = M_OUT * (M_IN * x)^e over GF(2).
module sms_power_engine
  import sms_pkg::*;
#(
  parameter int          N    = N_DEF,
  parameter logic [N:0]  POLY = POLY_DEF,
  parameter int          EW   = EW_DEF
`ifdef SMS_ISO_EN
  ,
  parameter logic [N*N-1:0] M_IN  = ID_MAT,
  parameter logic [N*N-1:0] M_OUT = ID_MAT
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  x_in,
  input  logic [EW-1:0] exp_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  y_out,
  output logic          busy
);

  localparam int CW = (EW > 1) ? $clog2(EW) : 1;

  state_t        state, state_n;
  logic [N-1:0]  base, acc;
  logic [EW-1:0] expo;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sq, prod, acc_nxt, base_in, y_res;

`ifdef SMS_ISO_EN
  // Row r of the result is the GF(2) dot product of matrix row r with v.
  function automatic logic [N-1:0] mat_vec(input logic [N*N-1:0] m,
                                            input logic [N-1:0]   v);
    mat_vec = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mat_vec[r] = mat_vec[r] ^ (m[r*N+c] & v[c]);
  endfunction

  assign base_in = mat_vec(M_IN, x_in);
  assign y_res   = mat_vec(M_OUT, acc);
`else
  assign base_in = x_in;
  assign y_res   = acc;
`endif

  gf_mul #(.N(N), .POLY(POLY)) u_sq  (.a(acc), .b(acc),  .p(sq));
  gf_mul #(.N(N), .POLY(POLY)) u_mul (.a(sq),  .b(base), .p(prod));

  assign acc_nxt = expo[cnt] ? prod : sq;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = RUN;
      RUN:     if (cnt == '0) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
      expo  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (in_valid) begin
          base <= base_in;
          expo <= exp_in;
          acc  <= N'(1);
          cnt  <= CW'(EW - 1);
        end
        RUN: begin
          acc <= acc_nxt;
          // Parks at zero so the DONE state sees a clean counter.
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  // Forced to zero outside DONE so the output never shows partial products.
  assign y_out     = (state == DONE) ? y_res : '0;

endmodule

// File: tb/tb_sms_power_engine.sv
// tb_sms_power_engine -- self-checking bench for sms_power_engine
// (default build, N=6, POLY=x^6+x+1, EW=6).
module tb_sms_power_engine;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [5:0] x_in, exp_in, y_out;
  logic       in_ready, out_valid, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sms_power_engine dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .busy(busy)
  );

  typedef struct {
    logic [5:0] x;
    logic [5:0] e;
    logic [5:0] y;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Carry-less product followed by a separate reduction pass.
  function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
    logic [11:0] p;
    logic [11:0] pl;
    p  = '0;
    pl = 12'b000001000011;
    for (int i = 0; i < 6; i++)
      if (b[i]) p = p ^ (12'(a) << i);
    for (int i = 11; i >= 6; i--)
      if (p[i]) p = p ^ (pl << (i - 6));
    return p[5:0];
  endfunction

  // Repeated multiplication, e times.
  function automatic logic [5:0] gpow(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'd1;
    for (int k = 0; k < e; k++) r = gmul(r, x);
    return r;
  endfunction

  // Issues one request and consumes the result. edges counts clock edges
  // with the accepting edge as edge 1; the edge after which out_valid is
  // first seen high is the result edge.
  task automatic run_req(input logic [5:0] x, input logic [5:0] e,
                         input bit rand_rdy,
                         output logic [5:0] y, output int edges);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("in_ready_wait", 0, 1);
    in_valid  = 1'b1;
    x_in      = x;
    exp_in    = e;
    out_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    y = y_out;
    for (int k = 0; k < 64; k++) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == 63) out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (out_ready) break;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] y;
    int         edges;
    int         w;

    tbl[0]  = '{6'h02, 6'd5,  6'h20};
    tbl[1]  = '{6'h02, 6'd6,  6'h03};
    tbl[2]  = '{6'h02, 6'd63, 6'h01};
    tbl[3]  = '{6'h00, 6'd0,  6'h01};
    tbl[4]  = '{6'h00, 6'd5,  6'h00};
    tbl[5]  = '{6'h2B, 6'd0,  6'h01};
    tbl[6]  = '{6'h2B, 6'd1,  6'h2B};
    tbl[7]  = '{6'h02, 6'd7,  6'h06};
    tbl[8]  = '{6'h03, 6'd2,  6'h05};
    tbl[9]  = '{6'h20, 6'd2,  6'h30};
    tbl[10] = '{6'h01, 6'd63, 6'h01};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; exp_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_y_out",     int'(y_out),     0);
    rst = 1'b0;

    // Directed vectors: value, latency, and return to IDLE.
    foreach (tbl[i]) begin
      run_req(tbl[i].x, tbl[i].e, 1'b0, y, edges);
      chk($sformatf("vec%0d_y", i), int'(y), int'(tbl[i].y));
      chk($sformatf("vec%0d_latency", i), edges, 7);
      chk($sformatf("vec%0d_idle", i), int'(in_ready), 1);
    end

    // Backpressure: result held for 10 cycles, new requests ignored.
    @(negedge clk);
    in_valid = 1'b1; x_in = 6'h02; exp_in = 6'd5; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_busy_run", int'(busy), 1);
    chk("bp_in_ready_run", int'(in_ready), 0);
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    if (!out_valid) chk("bp_timeout", 0, 1);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; x_in = 6'h3F; exp_in = 6'd1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_y_hold",    int'(y_out),     6'h20);
      chk("bp_in_ready",  int'(in_ready),  0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_in_ready",  int'(in_ready),  1);
    chk("bp_release_busy",      int'(busy),      0);
    run_req(6'h03, 6'd2, 1'b0, y, edges);
    chk("bp_next_y", int'(y), 6'h05);

    // Reset during RUN cycle 3, with in_valid and out_ready also high.
    @(negedge clk);
    in_valid = 1'b1; x_in = 6'h02; exp_in = 6'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("mid_rst_in_ready",  int'(in_ready),  1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy",      int'(busy),      0);
    chk("mid_rst_y_out",     int'(y_out),     0);
    run_req(6'h02, 6'd5, 1'b0, y, edges);
    chk("mid_after_y", int'(y), 6'h20);
    chk("mid_after_latency", edges, 7);

    // Exhaustive sweep with random consumer stalls.
    for (int xi = 0; xi < 64; xi++) begin
      for (int ei = 0; ei < 64; ei++) begin
        run_req(6'(xi), 6'(ei), 1'b1, y, edges);
        chk($sformatf("exh_x%0d_e%0d", xi, ei), int'(y), int'(gpow(6'(xi), ei)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
